// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the sequential ALU with hex display:
//   - opcode values for the command input
//   - FSM state encoding used by the top-level controller
//   - hex-digit to seven-segment lookup (active-high, bit0=a .. bit6=g)
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0101;
    localparam logic [3:0] OP_DIV = 4'b1010;
    localparam logic [3:0] OP_MOD = 4'b1011;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DIVIDE,
        DONE
    } state_t;

    // Entry n holds the segment pattern for hex digit n, {g,f,e,d,c,b,a}.
    // Letters use the usual mixed-case shapes: A b C d E F.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b1110001,   // F
        7'b1111001,   // E
        7'b1011110,   // d
        7'b0111001,   // C
        7'b1111100,   // b
        7'b1110111,   // A
        7'b1101111,   // 9
        7'b1111111,   // 8
        7'b0000111,   // 7
        7'b1111101,   // 6
        7'b1101101,   // 5
        7'b1100110,   // 4
        7'b1001111,   // 3
        7'b1011011,   // 2
        7'b0000110,   // 1
        7'b0111111    // 0
    };

endpackage

// File: rtl/seg7_scan.sv
// -----------------------------------------------------------------------------
// seg7_scan
// Time-multiplexed hex seven-segment driver. A free-running counter defines
// digit slots of SCAN_DIV clocks; at each slot boundary the active digit moves
// one position up (wrapping to digit 0) and the segment pattern for that
// digit's nibble of 'value' is latched, so digit_sel and display change in
// the same cycle.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (digit 0 selected, counter 0)
//   value      4*NDIG-bit value to show, nibble i on digit i
//   digit_sel  one-hot active-high digit enable, bit 0 = least-significant
//   display    active-high segments [0]=a .. [6]=g
// -----------------------------------------------------------------------------
module seg7_scan
    import alu_pkg::*;
#(
    parameter int NDIG     = 2,
    parameter int SCAN_DIV = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4*NDIG-1:0] value,
    output logic [NDIG-1:0]   digit_sel,
    output logic [6:0]        display
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);

    logic [CW-1:0] scan_cnt;
    logic [IW-1:0] idx;
    logic [IW-1:0] idx_next;
    logic [3:0]    nibble;

    // The digit index is kept in binary so the one-hot select and the nibble
    // mux both derive from it; this also keeps NDIG=1 legal.
    always_comb begin
        idx_next = (idx == IDX_LAST) ? '0 : idx + IW'(1);
        nibble   = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (idx_next == IW'(i)) begin
                nibble = value[4*i +: 4];
            end
        end
    end

    // Slot counter plus the registered digit select and segment outputs.
    // The pattern is only refreshed at a slot boundary, so a new value shows
    // up starting with the next digit slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt  <= '0;
            idx       <= '0;
            digit_sel <= NDIG'(1);
            display   <= SEG_TABLE[0];
        end else if (scan_cnt == CNT_LAST) begin
            scan_cnt  <= '0;
            idx       <= idx_next;
            digit_sel <= NDIG'(1) << idx_next;
            display   <= SEG_TABLE[nibble];
        end else begin
            scan_cnt  <= scan_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/seq_alu_display.sv
// -----------------------------------------------------------------------------
// seq_alu_display
// Width-generic sequential ALU (ADD, SUB, restoring DIV/MOD) with a
// start/busy/done handshake and a multiplexed hex readout of the last result.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             request, only sampled while idle
//   input_a, input_b  operands (captured on an accepted start)
//   command           opcode: 0001 ADD, 0101 SUB, 1010 DIV, 1011 MOD
//   busy              high whenever the controller is not idle
//   done              one-cycle pulse; result/carry/error valid from here on
//   result            registered result, held until the next done
//   carry             ADD/SUB carry-out (SUB: 1 = no borrow), else 0
//   error             ADD/SUB signed overflow, DIV/MOD divide by zero
//   display           active-high segments of the selected digit
//   digit_sel         one-hot digit enable, bit 0 = least-significant nibble
// -----------------------------------------------------------------------------
module seq_alu_display
    import alu_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int NDIG     = WIDTH / 4,
    parameter int SCAN_DIV = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] input_a,
    input  logic [WIDTH-1:0] input_b,
    input  logic [3:0]       command,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             error,
    output logic [6:0]       display,
    output logic [NDIG-1:0]  digit_sel
);

    localparam int DCW = $clog2(WIDTH + 1);
    localparam logic [DCW-1:0] DIV_LAST = DCW'(WIDTH - 1);
    localparam int VW = 4 * NDIG;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [DCW-1:0]   div_cnt;

    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic             carry_into_msb;
    logic             overflow;

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;

    logic             start_is_div;

    // Add/subtract share one adder: subtraction is a + ~b + 1. Signed
    // overflow is carry-out XOR the carry into the sign bit, which is
    // recovered from the sign bits of the operands and the sum.
    always_comb begin
        is_sub         = (op_q == OP_SUB);
        b_eff          = is_sub ? ~b_q : b_q;
        sum            = {1'b0, a_q} + {1'b0, b_eff} + (WIDTH + 1)'(is_sub);
        carry_into_msb = a_q[WIDTH-1] ^ b_eff[WIDTH-1] ^ sum[WIDTH-1];
        overflow       = sum[WIDTH] ^ carry_into_msb;
    end

    // One restoring-division step: shift the next dividend bit into the
    // partial remainder and subtract the divisor if it fits. The quotient
    // is built in the dividend register as its bits are shifted out.
    always_comb begin
        shifted  = {rem_q, quo_q[WIDTH-1]};
        fits     = (shifted >= {1'b0, b_q});
        diff     = shifted[WIDTH-1:0] - b_q;
        rem_next = fits ? diff : shifted[WIDTH-1:0];
        quo_next = {quo_q[WIDTH-2:0], fits};
    end

    // Next-state logic and handshake outputs. Divide by zero skips the
    // iterative path and is reported from EXEC like the single-cycle ops.
    always_comb begin
        state_next   = state;
        busy         = (state != IDLE);
        done         = (state == DONE);
        start_is_div = ((command == OP_DIV) || (command == OP_MOD)) && (input_b != '0);
        case (state)
            IDLE:    if (start) state_next = start_is_div ? DIVIDE : EXEC;
            EXEC:    state_next = DONE;
            DIVIDE:  if (div_cnt == DIV_LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operand capture, division iteration and result/flag registers.
    // Reset mid-operation simply drops the work; no done is produced.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            div_cnt <= '0;
            result  <= '0;
            carry   <= 1'b0;
            error   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q     <= input_a;
                        b_q     <= input_b;
                        op_q    <= command;
                        rem_q   <= '0;
                        quo_q   <= input_a;
                        div_cnt <= '0;
                    end
                end
                EXEC: begin
                    case (op_q)
                        OP_ADD, OP_SUB: begin
                            result <= sum[WIDTH-1:0];
                            carry  <= sum[WIDTH];
                            error  <= overflow;
                        end
                        OP_DIV, OP_MOD: begin
                            result <= '0;
                            carry  <= 1'b0;
                            error  <= 1'b1;
                        end
                        default: begin
                            result <= '0;
                            carry  <= 1'b0;
                            error  <= 1'b0;
                        end
                    endcase
                end
                DIVIDE: begin
                    rem_q   <= rem_next;
                    quo_q   <= quo_next;
                    div_cnt <= div_cnt + DCW'(1);
                    if (div_cnt == DIV_LAST) begin
                        result <= (op_q == OP_MOD) ? rem_next : quo_next;
                        carry  <= 1'b0;
                        error  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    seg7_scan #(
        .NDIG     (NDIG),
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .clk       (clk),
        .rst       (rst),
        .value     (VW'(result)),
        .digit_sel (digit_sel),
        .display   (display)
    );

endmodule

// File: tb/tb_seq_alu_display.sv
// -----------------------------------------------------------------------------
// tb_seq_alu_display
// Scoreboard bench for seq_alu_display (WIDTH=8, NDIG=2, SCAN_DIV=4).
// The stimulus pushes the hand-computed result, flags and done time for each
// operation; a negedge monitor pops and compares when done is seen, and also
// follows the digit scan with a reset-relative slot model.
// -----------------------------------------------------------------------------
module tb_seq_alu_display;

    localparam int W    = 8;
    localparam int ND   = 2;
    localparam int SCAN = 4;

    logic          clk;
    logic          rst;
    logic          start;
    logic [W-1:0]  input_a;
    logic [W-1:0]  input_b;
    logic [3:0]    command;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic          carry;
    logic          error;
    logic [6:0]    display;
    logic [ND-1:0] digit_sel;

    seq_alu_display #(
        .WIDTH    (W),
        .NDIG     (ND),
        .SCAN_DIV (SCAN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .input_a   (input_a),
        .input_b   (input_b),
        .command   (command),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry     (carry),
        .error     (error),
        .display   (display),
        .digit_sel (digit_sel)
    );

    typedef struct {
        logic [W-1:0] res;
        logic         c;
        logic         e;
        int           t;
    } exp_t;

    exp_t sbq[$];
    exp_t popped;

    int checks = 0;
    int errors = 0;
    logic checking_on = 1'b0;

    logic [6:0] seg_ref [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic [W-1:0]  exp_result;
    int            slot_j;
    logic [ND-1:0] msel;
    logic [6:0]    mdisp;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Expected scan: slot boundaries every SCAN edges counted from the last
    // reset edge; the latched pattern uses the result known before that edge.
    always @(posedge clk) begin
        if (rst) begin
            slot_j <= 0;
            msel   <= 2'b01;
            mdisp  <= seg_ref[0];
        end else begin
            slot_j <= slot_j + 1;
            if ((slot_j + 1) % SCAN == 0) begin
                if (((slot_j + 1) / SCAN) % ND == 1) begin
                    msel  <= 2'b10;
                    mdisp <= seg_ref[exp_result[7:4]];
                end else begin
                    msel  <= 2'b01;
                    mdisp <= seg_ref[exp_result[3:0]];
                end
            end
        end
    end

    // Monitor: scan outputs every cycle, scoreboard pop on each done pulse.
    always @(negedge clk) begin
        if (checking_on) begin
            checkOutput("digit_sel", 32'(digit_sel), 32'(msel));
            checkOutput("display", 32'(display), 32'(mdisp));
            if (done) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_done: done=1 with nothing outstanding, required 0");
                end else begin
                    popped = sbq.pop_front();
                    checkOutput("result", 32'(result), 32'(popped.res));
                    checkOutput("carry", 32'(carry), 32'(popped.c));
                    checkOutput("error", 32'(error), 32'(popped.e));
                    checkOutput("done_time", 32'($time), 32'(popped.t));
                    exp_result = popped.res;
                end
            end
        end
    end

    // Issue one operation and record what should come back and when.
    // lat is the number of edges from the start edge to done becoming visible.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [3:0] cmd, input logic [W-1:0] er,
                                 input logic ec, input logic ee, input int lat);
        exp_t x;
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        input_a = a;
        input_b = b;
        command = cmd;
        start   = 1'b1;
        x.res = er;
        x.c   = ec;
        x.e   = ee;
        x.t   = int'($time) + (lat + 1) * 10;
        sbq.push_back(x);
        @(negedge clk);
        start   = 1'b0;
        input_a = W'($urandom);
        input_b = W'($urandom);
        command = 4'($urandom);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        checkOutput("busy_len", 32'(n), 32'(lat + 1));
    endtask

    initial begin
        int n;
        rst        = 1'b1;
        start      = 1'b0;
        input_a    = '0;
        input_b    = '0;
        command    = '0;
        exp_result = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checking_on = 1'b1;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_result", 32'(result), 32'd0);
        checkOutput("reset_flags", 32'({carry, error}), 32'd0);

        // add / sub, including overflow and carry corners
        applyStimulus(8'h7F, 8'h01, 4'b0001, 8'h80, 1'b0, 1'b1, 1);
        applyStimulus(8'hFF, 8'h01, 4'b0001, 8'h00, 1'b1, 1'b0, 1);
        applyStimulus(8'h80, 8'h80, 4'b0001, 8'h00, 1'b1, 1'b1, 1);
        applyStimulus(8'h80, 8'h01, 4'b0101, 8'h7F, 1'b1, 1'b1, 1);
        applyStimulus(8'h01, 8'h02, 4'b0101, 8'hFF, 1'b0, 1'b0, 1);
        applyStimulus(8'h06, 8'h01, 4'b0101, 8'h05, 1'b1, 1'b0, 1);

        // "5" on digit 0 and "0" on digit 1 once a fresh slot has started
        repeat (8) @(negedge clk);
        n = 0;
        while (digit_sel != 2'b01 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("disp_digit0", 32'(display), 32'(7'b1101101));
        n = 0;
        while (digit_sel != 2'b10 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("disp_digit1", 32'(display), 32'(7'b0111111));

        // multi-cycle divide / modulo
        applyStimulus(8'd200, 8'd7, 4'b1010, 8'd28, 1'b0, 1'b0, W);
        applyStimulus(8'd200, 8'd7, 4'b1011, 8'd4, 1'b0, 1'b0, W);
        applyStimulus(8'd255, 8'd1, 4'b1010, 8'd255, 1'b0, 1'b0, W);
        applyStimulus(8'd255, 8'd16, 4'b1011, 8'd15, 1'b0, 1'b0, W);
        applyStimulus(8'd5, 8'd9, 4'b1010, 8'd0, 1'b0, 1'b0, W);
        applyStimulus(8'd5, 8'd9, 4'b1011, 8'd5, 1'b0, 1'b0, W);

        // divide by zero and an invalid opcode
        applyStimulus(8'h55, 8'h00, 4'b1010, 8'h00, 1'b0, 1'b1, 1);
        applyStimulus(8'h0A, 8'h00, 4'b1011, 8'h00, 1'b0, 1'b1, 1);
        applyStimulus(8'h12, 8'h34, 4'b0011, 8'h00, 1'b0, 1'b0, 1);
        repeat (10) @(negedge clk);

        // abort a divide: extra start mid-divide, then reset; no done follows
        input_a = 8'd200;
        input_b = 8'd7;
        command = 4'b1010;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_result = '0;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_result", 32'(result), 32'd0);
        checkOutput("abort_digit_sel", 32'(digit_sel), 32'd1);
        repeat (20) @(negedge clk);

        // one more add after the abort to show the unit recovered
        applyStimulus(8'h3C, 8'h0F, 4'b0001, 8'h4B, 1'b0, 1'b0, 1);
        repeat (12) @(negedge clk);

        checkOutput("pending", 32'(sbq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
